adder_share_arbiter: RTL and testbench
======================================

# adder_share_arbiter

Round-robin arbiter that shares one ripple-carry `adder` instance between `NUM_REQ` requesters (e.g. address-generation and branch-target consumers in the execute stage). It accepts at most one operand pair per cycle via per-requester valid/ready handshakes and presents the registered sum on a single-entry output stage with valid/ready backpressure. The output is tagged with the winning requester index.

## Interface
- `WIDTH`, 32: operand/sum width; ≥ 2, because the `adder` needs it.
- `NUM_REQ`, 4: number of requesters; ≥ 2, power of two.
- `SRC_W`, `$clog2(NUM_REQ)`: width of the source index. Derived; do not override.

- `clk` input 1: clock. All state updates on the rising edge.
- `rst_aL` input 1: asynchronous, active-low reset.
- `req_valid` input `NUM_REQ`: bit i is high when requester i presents operands.
- `req_a` input `NUM_REQ*WIDTH`: operand A. Requester i occupies `[i*WIDTH +: WIDTH]`.
- `req_b` input `NUM_REQ*WIDTH`: operand B, same packing as `req_a`.
- `req_ready` output `NUM_REQ`: bit i high means requester i is accepted this cycle. One-hot or zero.
- `out_valid` output 1: `out_sum` and `out_src` hold a result.
- `out_ready` input 1: the consumer takes the result this cycle.
- `out_sum` output `WIDTH`: registered (a+b) mod 2^WIDTH.
- `out_src` output `SRC_W`: index of the requester that produced `out_sum`.

## Operation
- Datapath: exactly one `adder #(.WIDTH(WIDTH))` instance. Its inputs are muxed from the granted requester's operands. Its output feeds the output register. The carry-out is discarded: the sum wraps modulo 2^WIDTH.
- `can_accept = !out_valid || out_ready`. The output stage can load this cycle when it is empty or is being drained at the same time.
- Arbitration uses a round-robin pointer `rr_ptr` (`SRC_W` bits).
  - The grant goes to the first i with `req_valid[i]` set, searching `rr_ptr`, `rr_ptr+1`, … with wrap mod `NUM_REQ`.
  - `req_ready[i] = can_accept && grant[i]`. This is combinational from `req_valid`, `out_valid` and `out_ready`.
  - Requesters must not make `req_valid` depend on `req_ready`.
- When `|req_ready` is high (accept):
  - `out_sum` ← granted a+b.
  - `out_src` ← granted index.
  - `out_valid` ← 1.
  - `rr_ptr` ← (granted index + 1) mod `NUM_REQ`.
- No accept, with `out_valid && out_ready`: `out_valid` ← 0. `out_sum` and `out_src` hold.
- No accept, no drain: all state holds. `rr_ptr` moves only on an accept.
- Stall (`out_valid && !out_ready`): `req_ready` is all zero. The output register and `rr_ptr` do not change.
- Operand stability: a requester must hold `req_a`/`req_b` steady while `req_valid` is high and `req_ready` is low. Only the values in the accept cycle are captured.
- Reset (async assert, any cycle including mid-transfer):
  - `out_valid` = 0, `out_sum` = 0, `out_src` = 0, `rr_ptr` = 0.
  - `req_ready` = 0 while `rst_aL` is low.
  - Any in-flight result is dropped.
- Fairness: with all requesters continuously valid and `out_ready` tied high, grants cycle 0,1,…,`NUM_REQ`-1,0,…. No requester waits more than `NUM_REQ`-1 accepts.

## Timing
- Latency: 1 cycle. An accept in cycle N gives `out_valid` = 1 with the sum in cycle N+1.
- Throughput: one operation per cycle when `out_ready` stays high. Back-to-back accepts happen with no bubble.
- Simultaneous drain and accept: the new result replaces the drained one in the same edge. `out_valid` stays 1.
- The combinational path `req_valid` → `req_ready` contains only the priority logic. The adder is not on it.
- The adder ripple path (`WIDTH` full-adder stages, from the operand mux to the output register D input) is the critical path.
- Async reset assert is immediate. Deassert is sampled on the next rising edge of `clk`.

## Test plan
- **Reset:** hold `rst_aL` low 3 cycles with random inputs -> `out_valid` = 0, `out_sum` = 0, `out_src` = 0, `req_ready` = 0. After release, the first grant with all valid goes to requester 0.
- **Single op and wrap:** requester 2 only, a = 0xFFFF_FFFF, b = 0x0000_0002 -> `req_ready` = 4'b0100. Next cycle `out_sum` = 0x0000_0001, `out_src` = 2, `out_valid` = 1.
- **Round robin:** all 4 valid for 8 cycles, `out_ready` = 1, a = i, b = 0x10 -> `out_src` sequence 0,1,2,3,0,1,2,3, with `out_sum` = 0x10+`out_src`. One result per cycle.
- **Backpressure:** result pending, `out_ready` = 0 for 3 cycles with requesters 1 and 3 valid -> `req_ready` = 0, and `out_sum`/`out_src`/`rr_ptr` are unchanged. In the cycle `out_ready` = 1, requester 1 is accepted (drain and accept on the same edge, `out_valid` stays 1).
- **Pointer skip:** `rr_ptr` = 1 and only requester 0 valid -> requester 0 is granted (search wraps). The pointer becomes 1 again.
- **Mid-operation reset:** assert `rst_aL` low asynchronously (between edges) while `out_valid` = 1 and `out_ready` = 0 -> `out_valid` drops without waiting for a clock edge. No stale result appears after release.

Source files
------------

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one ripple-carry adder between NUM_REQ requesters,
// with a single-entry registered output stage tagged by the winning requester.

module adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    // carry_s[i] is the carry into bit i; the carry out of the top bit is dropped
    logic [WIDTH-1:0] carry_s;

    assign carry_s[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_fa
            assign sum[gi] = a[gi] ^ b[gi] ^ carry_s[gi];
            if (gi < WIDTH - 1) begin : g_carry
                assign carry_s[gi+1] = (a[gi] & b[gi]) | (carry_s[gi] & (a[gi] ^ b[gi]));
            end
        end
    endgenerate

endmodule

module adder_share_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_aL,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_sum,
    output logic [SRC_W-1:0]         out_src
);

    logic [SRC_W-1:0] rr_ptr_r;
    logic [SRC_W-1:0] grant_idx_s;
    logic [SRC_W-1:0] cand_s;
    logic             grant_any_s;
    logic             can_accept_s;
    logic             accept_s;
    logic [WIDTH-1:0] a_arr_s [NUM_REQ];
    logic [WIDTH-1:0] b_arr_s [NUM_REQ];
    logic [WIDTH-1:0] a_mux_s;
    logic [WIDTH-1:0] b_mux_s;
    logic [WIDTH-1:0] sum_s;

    genvar ri;
    generate
        for (ri = 0; ri < NUM_REQ; ri++) begin : g_unpack
            assign a_arr_s[ri] = req_a[ri*WIDTH +: WIDTH];
            assign b_arr_s[ri] = req_b[ri*WIDTH +: WIDTH];
        end
    endgenerate

    // First valid requester at or after rr_ptr; SRC_W-bit addition wraps mod NUM_REQ
    always_comb begin
        grant_any_s = 1'b0;
        grant_idx_s = '0;
        cand_s      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = rr_ptr_r + SRC_W'(k);
            if (!grant_any_s && req_valid[cand_s]) begin
                grant_any_s = 1'b1;
                grant_idx_s = cand_s;
            end else begin
                grant_any_s = grant_any_s;
            end
        end
    end

    assign can_accept_s = !out_valid || out_ready;
    // rst_aL gating keeps req_ready low while held in reset, when out_valid alone would allow accept
    assign accept_s     = rst_aL && can_accept_s && grant_any_s;

    // One-hot ready for the granted requester, zero when stalled or idle
    always_comb begin
        req_ready = '0;
        if (accept_s) begin
            req_ready[grant_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Operand mux sits after arbitration so the adder stays off the ready path
    assign a_mux_s = a_arr_s[grant_idx_s];
    assign b_mux_s = b_arr_s[grant_idx_s];

    adder #(.WIDTH(WIDTH)) u_adder (
        .a   (a_mux_s),
        .b   (b_mux_s),
        .sum (sum_s)
    );

    // Output stage and round-robin pointer; the pointer advances only on accept
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_src   <= '0;
            rr_ptr_r  <= '0;
        end else if (accept_s) begin
            out_valid <= 1'b1;
            out_sum   <= sum_s;
            out_src   <= grant_idx_s;
            rr_ptr_r  <= grant_idx_s + SRC_W'(1);
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: a reference grant model predicts req_ready,
// and a queue scoreboard checks every result as it sits on the output.

module tb_adder_share_arbiter;

    localparam int WIDTH   = 32;
    localparam int NUM_REQ = 4;
    localparam int SRC_W   = 2;

    logic                     clk;
    logic                     rst_aL;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_sum;
    logic [SRC_W-1:0]         out_src;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] q_sum[$];
    logic [SRC_W-1:0] q_src[$];
    bit               m_valid;
    int               m_ptr;

    adder_share_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .clk       (clk),
        .rst_aL    (rst_aL),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_src   (out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_ptr   = 0;
        q_sum.delete();
        q_src.delete();
    endtask

    // Called at posedge+1 with inputs driven; checks this cycle, then advances one clock
    task automatic tick();
        int gi;
        int idx;
        bit can;
        logic [NUM_REQ-1:0] exp_ready;
        logic [WIDTH-1:0]   s;
        #1;
        gi = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (m_ptr + k) % NUM_REQ;
            if (gi < 0 && req_valid[idx]) gi = idx;
        end
        can       = !m_valid || out_ready;
        exp_ready = (can && gi >= 0) ? (4'b0001 << gi) : 4'b0000;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            if (q_sum.size() == 0) begin
                check("scoreboard_empty", 32'(q_sum.size()), 32'd1);
            end else begin
                check("out_sum", out_sum, q_sum[0]);
                check("out_src", 32'(out_src), 32'(q_src[0]));
                if (out_ready) begin
                    void'(q_sum.pop_front());
                    void'(q_src.pop_front());
                    m_valid = 1'b0;
                end
            end
        end
        if (exp_ready != 4'b0000) begin
            s = req_a[gi*WIDTH +: WIDTH] + req_b[gi*WIDTH +: WIDTH];
            q_sum.push_back(s);
            q_src.push_back(SRC_W'(gi));
            m_valid = 1'b1;
            m_ptr   = (gi + 1) % NUM_REQ;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_aL    = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        out_ready = 1'b0;
        model_reset();

        // Reset held for 3 cycles with random inputs
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            req_valid = 4'($urandom);
            for (int i = 0; i < NUM_REQ; i++) set_op(i, $urandom, $urandom);
            out_ready = 1'($urandom);
            #1;
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_sum", out_sum, 32'd0);
            check("rst_out_src", 32'(out_src), 32'd0);
            check("rst_req_ready", 32'(req_ready), 32'd0);
        end
        rst_aL    = 1'b1;
        out_ready = 1'b1;

        // First grant after reset with all valid goes to requester 0
        req_valid = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) set_op(i, 32'(100 + i), 32'd1);
        tick();
        req_valid = 4'b0000;
        tick();

        // Single op on requester 2 with wraparound
        req_valid = 4'b0100;
        set_op(2, 32'hFFFF_FFFF, 32'h0000_0002);
        tick();
        req_valid = 4'b0000;
        tick();
        check("wrap_sum_const", out_sum, 32'h0000_0001);
        check("wrap_src_const", 32'(out_src), 32'd2);

        // Bring pointer back to 0, then 8 cycles of full contention
        req_valid = 4'b1000;
        set_op(3, 32'h1234_5678, 32'h1111_1111);
        tick();
        req_valid = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) set_op(i, 32'(i), 32'h10);
        for (int c = 0; c < 8; c++) tick();
        req_valid = 4'b0000;
        tick();

        // Backpressure: pending result from requester 0, then stall with 1 and 3 valid
        req_valid = 4'b0001;
        set_op(0, 32'hA5A5_0000, 32'h0000_5A5A);
        tick();
        req_valid = 4'b1010;
        set_op(1, 32'h0000_0100, 32'h0000_0023);
        set_op(3, 32'h0000_0300, 32'h0000_0045);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        out_ready = 1'b1;
        tick();
        req_valid = 4'b0000;
        tick();

        // Pointer skip: only requester 0 valid wraps the search; pointer returns to 1
        req_valid = 4'b0001;
        set_op(0, 32'h0000_0007, 32'h0000_0008);
        tick();
        tick();
        req_valid = 4'b1111;
        tick();
        req_valid = 4'b0000;
        tick();

        // Mid-operation asynchronous reset with a stalled result
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b1111;
        out_ready = 1'b0;
        #3;
        rst_aL = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_sum", out_sum, 32'd0);
        check("midrst_out_src", 32'(out_src), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_aL    = 1'b1;
        model_reset();
        req_valid = 4'b0000;
        out_ready = 1'b1;
        tick();
        req_valid = 4'b1111;
        tick();
        req_valid = 4'b0000;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
